mem_access_ctrl: RTL and testbench

Sequencer for data-memory accesses issued by the MEM stage toward a variable-latency, req/ack data-memory port. It checks alignment, builds byte enables and lane-replicated store data, and holds a request until the memory acknowledges or a timeout expires. It stalls the pipeline for the duration of each access and delivers lane-aligned load data, which the write-back stage then sign- or zero-extends and merges.

---
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: alignment check, byte enables, lane-replicated
// store data, req/ack handshake with timeout, and lane-aligned load return.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Flush,
  input  logic [2:0]  Memfunc,
  input  logic [31:0] Address,
  input  logic [31:0] RtData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MemReq,
  output logic        MemWen,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        AddrErr,
  output logic        BusErr
);

  // state | meaning
  // IDLE  | waiting for a valid MEM-stage access
  // REQ   | request held on the bus until MemAck or timeout
  // DONE  | one-cycle completion, LoadValid for unsquashed loads
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] F_BS = 3'd0;
  localparam logic [2:0] F_BU = 3'd1;
  localparam logic [2:0] F_HS = 3'd2;
  localparam logic [2:0] F_HU = 3'd3;
  localparam logic [2:0] F_WL = 3'd5;
  localparam logic [2:0] F_WR = 3'd6;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [2:0]  r_func;
  logic [1:0]  r_off;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_ldata;
  logic        r_lvalid;
  logic        r_addrerr;
  logic        r_buserr;
  logic        r_squash;

  logic        w_valid;
  logic        w_misal;
  logic        w_accept;
  logic        w_in_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_valid  = (MemRead | MemWrite) & ~Flush;
  assign w_accept = (r_state == S_IDLE) & w_valid & ~w_misal;
  assign w_in_req = (r_state == S_REQ);

  // Unused encodings fall into the full-word case so they still get an alignment check
  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = RtData;
    case (Memfunc)
      F_BS, F_BU: begin
        w_be    = 4'b0001 << Address[1:0];
        w_wdata = {4{RtData[7:0]}};
      end
      F_HS, F_HU: begin
        w_misal = Address[0];
        w_be    = Address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{RtData[15:0]}};
      end
      F_WL:    w_be = 4'b1100;
      F_WR:    w_be = 4'b0011;
      default: w_misal = |Address[1:0];
    endcase
  end

  always_comb begin
    w_ldata = MemRData;
    case (r_func)
      F_BS, F_BU: w_ldata = {24'b0, MemRData[{r_off, 3'b000} +: 8]};
      F_HS, F_HU: w_ldata = {16'b0, r_off[1] ? MemRData[31:16] : MemRData[15:0]};
      default:    w_ldata = MemRData;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_addr    <= 32'd0;
      r_wen     <= 1'b0;
      r_func    <= 3'd0;
      r_off     <= 2'd0;
      r_be      <= 4'd0;
      r_wdata   <= 32'd0;
      r_ldata   <= 32'd0;
      r_lvalid  <= 1'b0;
      r_addrerr <= 1'b0;
      r_buserr  <= 1'b0;
      r_squash  <= 1'b0;
    end else begin
      r_addrerr <= (r_state == S_IDLE) & w_valid & w_misal;
      r_buserr  <= w_in_req & ~MemAck & (r_cnt == CNT_LAST);
      r_lvalid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= {Address[31:2], 2'b00};
            r_wen    <= MemWrite;
            r_func   <= Memfunc;
            r_off    <= Address[1:0];
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_cnt    <= 8'd0;
            r_squash <= 1'b0;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (Flush) r_squash <= 1'b1;
          // Ack wins over a timeout landing in the same cycle
          if (MemAck) begin
            if (!r_wen) r_ldata <= w_ldata;
            r_lvalid <= ~r_wen & ~r_squash & ~Flush;
            r_state  <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MemReq    = w_in_req;
  assign MemWen    = r_wen & w_in_req;
  assign MemAddr   = r_addr;
  assign MemBE     = r_be;
  assign MemWData  = r_wdata;
  assign Stall     = w_accept | w_in_req;
  assign LoadData  = r_ldata;
  assign LoadValid = r_lvalid;
  assign AddrErr   = r_addrerr;
  assign BusErr    = r_buserr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against an arithmetic
// reference model of byte enables, lane replication, load alignment and timing.
module tb_mem_access_ctrl;

  localparam int TO = 4;
  localparam logic [2:0] F_BS = 3'd0;
  localparam logic [2:0] F_BU = 3'd1;
  localparam logic [2:0] F_HS = 3'd2;
  localparam logic [2:0] F_HU = 3'd3;
  localparam logic [2:0] F_WD = 3'd4;
  localparam logic [2:0] F_WL = 3'd5;
  localparam logic [2:0] F_WR = 3'd6;

  logic        clk, rst;
  logic        MemRead, MemWrite, Flush, MemAck;
  logic [2:0]  Memfunc;
  logic [31:0] Address, RtData, MemRData;
  logic        MemReq, MemWen, Stall, LoadValid, AddrErr, BusErr;
  logic [31:0] MemAddr, MemWData, LoadData;
  logic [3:0]  MemBE;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Flush(Flush),
    .Memfunc(Memfunc), .Address(Address), .RtData(RtData), .MemAck(MemAck),
    .MemRData(MemRData), .MemReq(MemReq), .MemWen(MemWen), .MemAddr(MemAddr),
    .MemBE(MemBE), .MemWData(MemWData), .Stall(Stall), .LoadData(LoadData),
    .LoadValid(LoadValid), .AddrErr(AddrErr), .BusErr(BusErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_byte(input logic [2:0] f);
    return f == F_BS || f == F_BU;
  endfunction

  function automatic bit is_half(input logic [2:0] f);
    return f == F_HS || f == F_HU;
  endfunction

  function automatic bit misaligned(input logic [2:0] f, input logic [31:0] a);
    if (is_half(f)) return a[0];
    if (f == F_WD) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
    if (is_byte(f)) return 4'(1 << a[1:0]);
    if (is_half(f)) return 4'(3 << (2 * int'(a[1])));
    if (f == F_WL) return 4'hC;
    if (f == F_WR) return 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f, input logic [31:0] d);
    if (is_byte(f)) return 32'(d[7:0]) * 32'h01010101;
    if (is_half(f)) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] r);
    if (is_byte(f)) return (r >> (8 * int'(a[1:0]))) & 32'hFF;
    if (is_half(f)) return (r >> (16 * int'(a[1]))) & 32'hFFFF;
    return r;
  endfunction

  // ack_k: REQ cycle index carrying MemAck (>= TO means never); flush_k: REQ cycle with Flush (-1 none)
  task automatic do_acc(input bit rd, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdata,
                        input int ack_k, input int flush_k);
    bit mis, acked, exp_lv;
    int nreq;
    mis    = misaligned(f, a);
    acked  = ack_k < TO;
    nreq   = acked ? ack_k + 1 : TO;
    exp_lv = rd && acked && !(flush_k >= 0 && flush_k <= ack_k);
    @(negedge clk);
    MemRead = rd; MemWrite = !rd; Memfunc = f; Address = a; RtData = d;
    #1;
    chk("stall_accept", 32'(Stall), 32'(!mis));
    chk("req_idle", 32'(MemReq), 32'd0);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    Address = $urandom; RtData = $urandom; Memfunc = 3'($urandom_range(0, 6));
    if (mis) begin
      #1;
      chk("addrerr_pulse", 32'(AddrErr), 32'd1);
      chk("addrerr_noreq", 32'(MemReq), 32'd0);
      chk("addrerr_stall", 32'(Stall), 32'd0);
      @(negedge clk); #1;
      chk("addrerr_clear", 32'(AddrErr), 32'd0);
      return;
    end
    for (int k = 0; k < nreq; k++) begin
      MemAck = (k == ack_k);
      Flush = (k == flush_k);
      MemRData = (k == ack_k) ? rdata : $urandom;
      #1;
      chk("req_high", 32'(MemReq), 32'd1);
      chk("req_wen", 32'(MemWen), 32'(!rd));
      chk("req_addr", MemAddr, {a[31:2], 2'b00});
      chk("req_be", 32'(MemBE), 32'(exp_be(f, a)));
      if (!rd) chk("req_wdata", MemWData, exp_wdata(f, d));
      chk("req_stall", 32'(Stall), 32'd1);
      chk("req_lvalid", 32'(LoadValid), 32'd0);
      @(negedge clk);
    end
    MemAck = 1'b0; Flush = 1'b0;
    #1;
    chk("end_req_low", 32'(MemReq), 32'd0);
    chk("end_stall", 32'(Stall), 32'd0);
    chk("end_buserr", 32'(BusErr), 32'(!acked));
    chk("end_lvalid", 32'(LoadValid), 32'(exp_lv));
    if (exp_lv) chk("end_ldata", LoadData, exp_load(f, a, rdata));
    @(negedge clk); #1;
    chk("post_lvalid", 32'(LoadValid), 32'd0);
    chk("post_buserr", 32'(BusErr), 32'd0);
  endtask

  initial begin
    rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Flush = 1'b0; MemAck = 1'b0;
    Memfunc = 3'd0; Address = 32'd0; RtData = 32'd0; MemRData = 32'd0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(MemReq), 32'd0);
    chk("rst_addr", MemAddr, 32'd0);
    chk("rst_be", 32'(MemBE), 32'd0);
    chk("rst_ldata", LoadData, 32'd0);
    chk("rst_flags", {28'd0, LoadValid, AddrErr, BusErr, Stall}, 32'd0);
    rst = 1'b0;

    do_acc(1, F_BU, 32'h1003, 32'h0, 32'hAABBCCDD, 0, -1);
    chk("bu_value", LoadData, 32'h000000AA);
    do_acc(0, F_HS, 32'h2002, 32'h12345678, 32'h0, 3, -1);
    do_acc(1, F_WD, 32'h3001, 32'h0, 32'h0, 0, -1);
    do_acc(1, F_WD, 32'h5000, 32'h0, 32'h11112222, TO, -1);
    do_acc(1, F_WD, 32'h5004, 32'h0, 32'h33334444, TO - 1, -1);
    do_acc(1, F_WD, 32'h4000, 32'h0, 32'h55556666, 2, 1);
    do_acc(1, F_HU, 32'h7002, 32'h0, 32'hBEEF1234, 1, -1);
    do_acc(1, F_WL, 32'h7003, 32'h0, 32'h0BADF00D, 0, -1);

    // A flushed instruction in IDLE is not an access at all
    @(negedge clk);
    MemRead = 1'b1; Memfunc = F_WD; Address = 32'h8000; Flush = 1'b1;
    #1 chk("flush_idle_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    MemRead = 1'b0; Flush = 1'b0;
    #1 chk("flush_idle_noreq", 32'(MemReq), 32'd0);

    for (int i = 0; i < 40; i++) begin
      do_acc(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 6)), $urandom, $urandom,
             $urandom, int'($urandom_range(0, TO)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : -1);
    end

    do_acc(1, F_BS, 32'h9001, 32'h0, 32'h00C30000, 0, -1);
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Memfunc = F_WD; Address = 32'h6000;
    @(negedge clk);
    MemRead = 1'b0;
    #1 chk("mid_req_high", 32'(MemReq), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(MemReq), 32'd0);
    chk("mid_rst_addr", MemAddr, 32'd0);
    chk("mid_rst_be_wdata", {MemBE, MemWData[27:0]}, 32'd0);
    chk("mid_rst_ldata", LoadData, 32'd0);
    chk("mid_rst_flags", {27'd0, MemWen, LoadValid, AddrErr, BusErr, Stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_buserr", 32'(BusErr), 32'd0);
    do_acc(1, F_WD, 32'h6004, 32'h0, 32'hCAFEF00D, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
